// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: compare-op encoding, predictor
// counter states and the saturating predictor step function.
package branch_pkg;

    typedef enum logic [2:0] {
        EQ  = 3'b000,
        NE  = 3'b001,
        GEZ = 3'b010,
        GTZ = 3'b011,
        LEZ = 3'b100,
        LTZ = 3'b101
    } comp_op_t;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    localparam bht_state_t BHT_RESET = WNT;

    // Two-bit saturating counter step: taken moves toward ST, not-taken toward SNT.
    function automatic bht_state_t bhtStep(input bht_state_t cur, input logic taken);
        bht_state_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = bht_state_t'(cur + 2'd1);
        end else begin
            if (cur != SNT) nxt = bht_state_t'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch-lookup / decode-resolve bundle between the front end and the resolve unit.
interface branch_resolve_unit_if #(
    parameter int WIDTH     = 32,
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
);
    logic [PC_WIDTH-1:0]  pc_f;
    logic                 pred_taken_f;
    logic                 valid_d;
    logic [PC_WIDTH-1:0]  pc_d;
    logic [WIDTH-1:0]     a_d;
    logic [WIDTH-1:0]     b_d;
    logic [2:0]           comp_op_d;
    logic                 pred_taken_d;
    logic                 stall_d;
    logic                 flush_d;
    logic                 res_valid_e;
    logic                 taken_e;
    logic                 mispredict_e;
    logic [CNT_WIDTH-1:0] branch_cnt;
    logic [CNT_WIDTH-1:0] mispred_cnt;

    modport master (
        output pc_f, valid_d, pc_d, a_d, b_d, comp_op_d, pred_taken_d, stall_d, flush_d,
        input  pred_taken_f, res_valid_e, taken_e, mispredict_e, branch_cnt, mispred_cnt
    );

    modport slave (
        input  pc_f, valid_d, pc_d, a_d, b_d, comp_op_d, pred_taken_d, stall_d, flush_d,
        output pred_taken_f, res_valid_e, taken_e, mispredict_e, branch_cnt, mispred_cnt
    );

endinterface

// File: rtl/branch_resolve_unit_bht.sv
// Branch history table: one combinational read port, one synchronous update
// port, each entry a 2-bit saturating counter. Reads see the pre-update value.
module bht
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    localparam int IDX        = $clog2(BHT_ENTRIES)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IDX-1:0] rdIdx,
    output logic           rdTaken,
    input  logic           updEn,
    input  logic [IDX-1:0] updIdx,
    input  logic           updTaken
);

    bht_state_t entryVal [BHT_ENTRIES];

    generate
        for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : gEntry
            bht_state_t entryReg;
            bht_state_t entryNext;

            always_comb begin
                entryNext = entryReg;
                if (updEn && (updIdx == IDX'(gi))) entryNext = bhtStep(entryReg, updTaken);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) entryReg <= BHT_RESET;
                else        entryReg <= entryNext;
            end

            assign entryVal[gi] = entryReg;
        end
    endgenerate

    // Prediction is the counter's upper bit.
    assign rdTaken = entryVal[rdIdx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolution: evaluates the condition, registers the outcome
// and mispredict, updates the predictor table and keeps saturating statistics.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PC_WIDTH    = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_WIDTH   = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    branch_resolve_unit_if.slave bus
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    logic                 condNext;
    logic                 resolveNext;
    logic                 mispredNext;
    logic                 aNeg;
    logic                 aZero;
    logic                 resValidReg;
    logic                 takenReg;
    logic                 mispredReg;
    logic [CNT_WIDTH-1:0] branchCntReg;
    logic [CNT_WIDTH-1:0] mispredCntReg;
    logic                 unusedPcBits;

    assign aNeg  = bus.a_d[WIDTH-1];
    assign aZero = (bus.a_d == '0);

    always_comb begin
        condNext = 1'b0;
        case (bus.comp_op_d)
            EQ:      condNext = (bus.a_d == bus.b_d);
            NE:      condNext = (bus.a_d != bus.b_d);
            GEZ:     condNext = ~aNeg;
            GTZ:     condNext = ~aNeg & ~aZero;
            LEZ:     condNext = aNeg | aZero;
            LTZ:     condNext = aNeg;
            default: condNext = 1'b0;
        endcase
    end

    // Flush dominates stall; either one suppresses the resolve.
    assign resolveNext = bus.valid_d & ~bus.stall_d & ~bus.flush_d;
    assign mispredNext = resolveNext & (condNext != bus.pred_taken_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resValidReg   <= 1'b0;
            takenReg      <= 1'b0;
            mispredReg    <= 1'b0;
            branchCntReg  <= '0;
            mispredCntReg <= '0;
        end else begin
            resValidReg <= resolveNext;
            takenReg    <= resolveNext & condNext;
            mispredReg  <= mispredNext;
            if (resolveNext && !(&branchCntReg))
                branchCntReg <= branchCntReg + CNT_WIDTH'(1);
            if (mispredNext && !(&mispredCntReg))
                mispredCntReg <= mispredCntReg + CNT_WIDTH'(1);
        end
    end

    bht #(
        .BHT_ENTRIES (BHT_ENTRIES)
    ) uBht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rdIdx    (bus.pc_f[IDX+1:2]),
        .rdTaken  (bus.pred_taken_f),
        .updEn    (resolveNext),
        .updIdx   (bus.pc_d[IDX+1:2]),
        .updTaken (condNext)
    );

    assign bus.res_valid_e  = resValidReg;
    assign bus.taken_e      = takenReg;
    assign bus.mispredict_e = mispredReg;
    assign bus.branch_cnt   = branchCntReg;
    assign bus.mispred_cnt  = mispredCntReg;

    // Only the index field of each PC addresses the table.
    assign unusedPcBits = ^{bus.pc_f, bus.pc_d};

endmodule
